// File: rtl/tea_pkg.sv
// Shared TEA definitions used by both the cipher and decipher blocks.
package tea_pkg;

  localparam int          WORD_SIZE_DEFAULT    = 16;
  localparam logic [31:0] DELTA_DEFAULT        = 32'h9e3779b9;
  localparam int          ROUND_NUMBER_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tea_state_e;

endpackage

// File: rtl/tea_round_dec.sv
// One combinational TEA decipher round: undo v1 first, then v0 using the new v1.
module tea_round_dec #(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] v0,
  input  logic [WORD_SIZE-1:0] v1,
  input  logic [WORD_SIZE-1:0] sum,
  input  logic [WORD_SIZE-1:0] k0,
  input  logic [WORD_SIZE-1:0] k1,
  input  logic [WORD_SIZE-1:0] k2,
  input  logic [WORD_SIZE-1:0] k3,
  output logic [WORD_SIZE-1:0] v0_next,
  output logic [WORD_SIZE-1:0] v1_next
);

  logic [WORD_SIZE-1:0] mix_v0;
  logic [WORD_SIZE-1:0] mix_v1;

  // Shifts stay inside WORD_SIZE bits, so bits pushed out are dropped and zeros fill in.
  always_comb begin
    mix_v0  = ((v0 << 4) + k2) ^ (v0 + sum) ^ ((v0 >> 5) + k3);
    v1_next = v1 - mix_v0;
    mix_v1  = ((v1_next << 4) + k0) ^ (v1_next + sum) ^ ((v1_next >> 5) + k1);
    v0_next = v0 - mix_v1;
  end

endmodule

// File: rtl/tea_decipher.sv
// Iterative TEA decipher: one round per clock, registered plaintext outputs.
//
// state   | meaning
// IDLE    | waiting for iStart; inputs are latched on acceptance
// RUN     | one decipher round per cycle until the last round
// DONE    | oDone pulse, results valid; returns to IDLE next cycle
module tea_decipher
  import tea_pkg::*;
#(
  parameter int          WORD_SIZE    = WORD_SIZE_DEFAULT,
  parameter logic [31:0] DELTA        = DELTA_DEFAULT,
  parameter int          ROUND_NUMBER = ROUND_NUMBER_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [WORD_SIZE-1:0] iV0,
  input  logic [WORD_SIZE-1:0] iV1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic [WORD_SIZE-1:0] oP0,
  output logic [WORD_SIZE-1:0] oP1,
  output logic                 oDone,
  output logic                 oBusy
);

  // The starting sum is DELTA*ROUND_NUMBER reduced to the word width; the
  // 32-bit product already wraps correctly for any WORD_SIZE up to 32.
  localparam logic [31:0]          SUM_INIT_FULL = 32'(DELTA * ROUND_NUMBER);
  localparam logic [WORD_SIZE-1:0] SUM_INIT      = SUM_INIT_FULL[WORD_SIZE-1:0];
  localparam logic [WORD_SIZE-1:0] DELTA_W       = DELTA[WORD_SIZE-1:0];
  localparam logic [7:0]           LAST_CNT      = 8'(ROUND_NUMBER - 1);

  tea_state_e state_q, state_d;

  logic [7:0]           cnt_q;
  logic [WORD_SIZE-1:0] sum_q;
  logic [WORD_SIZE-1:0] v0_q, v1_q;
  logic [WORD_SIZE-1:0] k0_q, k1_q, k2_q, k3_q;
  logic [WORD_SIZE-1:0] p0_q, p1_q;
  logic [WORD_SIZE-1:0] v0_next, v1_next;
  logic                 last_round;

  tea_round_dec #(
    .WORD_SIZE(WORD_SIZE)
  ) u_round (
    .v0     (v0_q),
    .v1     (v1_q),
    .sum    (sum_q),
    .k0     (k0_q),
    .k1     (k1_q),
    .k2     (k2_q),
    .k3     (k3_q),
    .v0_next(v0_next),
    .v1_next(v1_next)
  );

  assign last_round = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; iStart only matters in IDLE.
  always_comb begin
    state_d = state_q;
    oDone   = 1'b0;
    oBusy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (iStart) state_d = ST_RUN;
      end
      ST_RUN: begin
        oBusy = 1'b1;
        if (last_round) state_d = ST_DONE;
      end
      ST_DONE: begin
        oBusy   = 1'b1;
        oDone   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch on acceptance, one round per RUN cycle, result capture on the last round.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      v0_q  <= '0;
      v1_q  <= '0;
      k0_q  <= '0;
      k1_q  <= '0;
      k2_q  <= '0;
      k3_q  <= '0;
      p0_q  <= '0;
      p1_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            v0_q  <= iV0;
            v1_q  <= iV1;
            k0_q  <= iK0;
            k1_q  <= iK1;
            k2_q  <= iK2;
            k3_q  <= iK3;
            sum_q <= SUM_INIT;
            cnt_q <= '0;
          end
        end
        ST_RUN: begin
          v0_q  <= v0_next;
          v1_q  <= v1_next;
          sum_q <= sum_q - DELTA_W;
          cnt_q <= cnt_q + 8'd1;
          if (last_round) begin
            p0_q <= v0_next;
            p1_q <= v1_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign oP0 = p0_q;
  assign oP1 = p1_q;

endmodule

// File: tb/tb_tea_decipher.sv
// Scoreboard bench for tea_decipher: ciphertext comes from a TEA encipher model,
// expected results are the original plaintext constants.
module tb_tea_decipher;

  logic        clk;
  logic        rst;
  logic        iStart;
  logic [15:0] iV0, iV1, iK0, iK1, iK2, iK3;
  logic [15:0] oP0, oP1;
  logic        oDone, oBusy;

  typedef struct packed {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          tests;
  int          fails;
  int          done_seen;
  int          done_expected;
  logic [31:0] cyc;
  logic [31:0] last_done_cyc;
  logic        prev_done;

  tea_decipher dut (
    .clk   (clk),
    .rst   (rst),
    .iStart(iStart),
    .iV0   (iV0),
    .iV1   (iV1),
    .iK0   (iK0),
    .iK1   (iK1),
    .iK2   (iK2),
    .iK3   (iK3),
    .oP0   (oP0),
    .oP1   (oP1),
    .oDone (oDone),
    .oBusy (oBusy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference TEA encipher with 16-bit words, default delta and 32 rounds.
  function automatic logic [31:0] tea_enc(input logic [15:0] p0, input logic [15:0] p1,
                                          input logic [15:0] k0, input logic [15:0] k1,
                                          input logic [15:0] k2, input logic [15:0] k3);
    logic [15:0] a, b, s;
    a = p0;
    b = p1;
    s = 16'h0000;
    for (int r = 0; r < 32; r++) begin
      s = s + 16'h79b9;
      a = a + ((((b << 4) + k0) ^ (b + s) ^ ((b >> 5) + k1)));
      b = b + ((((a << 4) + k2) ^ (a + s) ^ ((a >> 5) + k3)));
    end
    return {a, b};
  endfunction

  // Monitor: pops the scoreboard on every oDone and checks data, latency and sum invariant.
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) check("done_single_cycle", {31'd0, oDone}, 32'd0);
      prev_done = oDone;
      if (oDone) begin
        exp_t e;
        done_seen++;
        last_done_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("p0", {16'd0, oP0}, {16'd0, e.p0});
          check("p1", {16'd0, oP1}, {16'd0, e.p1});
          check("done_latency", cyc, e.cyc);
          check("sum_at_done", {16'd0, dut.sum_q}, 32'd0);
        end
      end
    end
  end

  // Drive a request for plaintext (p0,p1) under the given key; ciphertext from the model.
  task automatic start_req(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] k0, input logic [15:0] k1,
                           input logic [15:0] k2, input logic [15:0] k3,
                           input bit expect_done, input bit hold_start);
    logic [31:0] c;
    exp_t e;
    c = tea_enc(p0, p1, k0, k1, k2, k3);
    iV0 = c[31:16];
    iV1 = c[15:0];
    iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
    iStart = 1'b1;
    @(posedge clk);
    #1;
    if (expect_done) begin
      e.p0 = p0;
      e.p1 = p1;
      e.cyc = cyc + 32;
      sb.push_back(e);
      done_expected++;
    end
    if (!hold_start) iStart = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (oDone) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [31:0] first_done;
    tests = 0;
    fails = 0;
    done_seen = 0;
    done_expected = 0;
    last_done_cyc = '0;
    rst = 1'b0;
    iStart = 1'b1;
    iV0 = 16'h1111; iV1 = 16'h2222;
    iK0 = 16'h3333; iK1 = 16'h4444; iK2 = 16'h5555; iK3 = 16'h6666;

    // Reset held for two edges with iStart high.
    repeat (2) @(posedge clk);
    #1;
    check("rst_p0", {16'd0, oP0}, 32'd0);
    check("rst_p1", {16'd0, oP1}, 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    iStart = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("no_accept_after_rst", {31'd0, oBusy}, 32'd0);

    // Round trip with the reference vector.
    start_req(16'h5986, 16'h6d67, 16'hcf42, 16'hcb45, 16'hacbe, 16'hf235, 1'b1, 1'b0);
    check("busy_in_run", {31'd0, oBusy}, 32'd1);
    wait_done("wait_roundtrip");
    repeat (3) @(posedge clk);
    #1;
    check("hold_p0", {16'd0, oP0}, 32'h5986);
    check("hold_p1", {16'd0, oP1}, 32'h6d67);
    check("idle_busy", {31'd0, oBusy}, 32'd0);

    // All-zero vector and key.
    start_req(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    wait_done("wait_zero");
    repeat (2) @(posedge clk);
    #1;

    // Busy immunity: iStart stays high and inputs churn during RUN.
    start_req(16'h5986, 16'h6d67, 16'hcf42, 16'hcb45, 16'hacbe, 16'hf235, 1'b1, 1'b1);
    for (int i = 0; i < 29; i++) begin
      iV0 = 16'($urandom);
      iK0 = 16'($urandom);
      iV1 = 16'($urandom);
      @(posedge clk);
      #1;
    end
    iStart = 1'b0;
    wait_done("wait_immunity");
    repeat (2) @(posedge clk);
    #1;

    // Abort at round 10; no completion expected.
    start_req(16'h5986, 16'h6d67, 16'hcf42, 16'hcb45, 16'hacbe, 16'hf235, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_p0", {16'd0, oP0}, 32'd0);
    check("abort_p1", {16'd0, oP1}, 32'd0);
    check("abort_busy", {31'd0, oBusy}, 32'd0);
    check("abort_done", {31'd0, oDone}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, done_expected);
    start_req(16'h5986, 16'h6d67, 16'hcf42, 16'hcb45, 16'hacbe, 16'hf235, 1'b1, 1'b0);
    wait_done("wait_after_abort");

    // Back-to-back: second request in the idle cycle right after DONE.
    repeat (2) @(posedge clk);
    #1;
    start_req(16'hbeef, 16'h0102, 16'h1a2b, 16'h3c4d, 16'h5e6f, 16'h7081, 1'b1, 1'b0);
    wait_done("wait_b2b_a");
    first_done = cyc;
    @(posedge clk);
    #1;
    start_req(16'h1234, 16'habcd, 16'h0f1e, 16'h2d3c, 16'h4b5a, 16'h6978, 1'b1, 1'b0);
    wait_done("wait_b2b_b");
    check("b2b_spacing", cyc - first_done, 32'd34);

    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_seen, done_expected);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
